// File: rtl/input_debounce.sv
// Per-channel switch debouncer: two-flop synchronizer, stability counter,
// registered debounced level plus rise/fall pulses and a rise-driven toggle.
module input_debounce #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_DATA,
  output logic [WIDTH-1:0] o_DATA,
  output logic [WIDTH-1:0] o_RISE,
  output logic [WIDTH-1:0] o_FALL,
  output logic [WIDTH-1:0] o_TOGGLE
);

  localparam int unsigned   CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]           sync1_q, sync2_q;
  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]           data_q, data_d;
  logic [WIDTH-1:0]           rise_q, fall_q, toggle_q;

  // Bring the asynchronous switch levels into the clock domain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_DATA;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreeing samples; commit the new level on the last one.
  always_comb begin
    data_d = data_q;
    cnt_d  = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (sync2_q[b] != data_q[b]) begin
        if (cnt_q[b] == CntLast) begin
          data_d[b] = sync2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CntW'(1);
        end
      end
    end
  end

  // Debounced level, edge pulses and toggle all update on the commit edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      data_q   <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      toggle_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rise_q   <= data_d & ~data_q;
      fall_q   <= ~data_d & data_q;
      toggle_q <= toggle_q ^ (data_d & ~data_q);
    end
  end

  assign o_DATA   = data_q;
  assign o_RISE   = rise_q;
  assign o_FALL   = fall_q;
  assign o_TOGGLE = toggle_q;

endmodule
